// File: rtl/reg_pair_sequencer.sv
// Sequences 16-bit BC/DE/HL read, write, increment and decrement commands into ordered
// byte accesses on an 8-bit register file port, high byte first.
module reg_pair_sequencer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [1:0]  cmd_pair_i,
    input  logic [15:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        regEn_o,
    output logic        regRW_o,
    output logic [2:0]  regSel_o,
    output logic [7:0]  regWdata_o,
    input  logic [7:0]  regRdata_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRdHi,
        StRdLo,
        StRdWait,
        StWrHi,
        StWrLo,
        StResp
    } state_e;

    localparam logic [1:0] OpRead   = 2'b00;
    localparam logic [1:0] OpWrite  = 2'b01;
    localparam logic [1:0] OpDec    = 2'b11;
    localparam logic [1:0] PairNone = 2'b11;

    state_e      state_q;
    logic [1:0]  op_q;
    logic [1:0]  pair_q;
    logic [7:0]  hi_q;
    logic [15:0] result_q;

    logic [2:0]  hi_sel;
    logic [2:0]  lo_sel;
    logic [15:0] rd_word;
    logic [15:0] arith;

    // Pair code doubles as the upper bits of the byte select: B/C, D/E, H/L.
    assign hi_sel  = {pair_q, 1'b0};
    assign lo_sel  = {pair_q, 1'b1};
    assign rd_word = {hi_q, regRdata_i};
    assign arith   = (op_q == OpDec) ? rd_word - 16'd1 : rd_word + 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            op_q        <= OpRead;
            pair_q      <= 2'b00;
            hi_q        <= 8'h00;
            result_q    <= 16'h0000;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 16'h0000;
            rsp_err_o   <= 1'b0;
            regEn_o     <= 1'b0;
            regRW_o     <= 1'b0;
            regSel_o    <= 3'b000;
            regWdata_o  <= 8'h00;
        end else begin
            // Access strobes last exactly one cycle unless a state below re-asserts them.
            regEn_o    <= 1'b0;
            regRW_o    <= 1'b0;
            regSel_o   <= 3'b000;
            regWdata_o <= 8'h00;

            case (state_q)
                StIdle: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        op_q        <= cmd_op_i;
                        pair_q      <= cmd_pair_i;
                        if (cmd_pair_i == PairNone) begin
                            state_q     <= StResp;
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= 16'h0000;
                            rsp_err_o   <= 1'b1;
                        end else if (cmd_op_i == OpWrite) begin
                            state_q    <= StWrHi;
                            result_q   <= cmd_wdata_i;
                            regEn_o    <= 1'b1;
                            regRW_o    <= 1'b1;
                            regSel_o   <= {cmd_pair_i, 1'b0};
                            regWdata_o <= cmd_wdata_i[15:8];
                        end else begin
                            state_q  <= StRdHi;
                            regEn_o  <= 1'b1;
                            regSel_o <= {cmd_pair_i, 1'b0};
                        end
                    end
                end
                StRdHi: begin
                    state_q  <= StRdLo;
                    regEn_o  <= 1'b1;
                    regSel_o <= lo_sel;
                end
                StRdLo: begin
                    state_q <= StRdWait;
                    hi_q    <= regRdata_i;
                end
                StRdWait: begin
                    if (op_q == OpRead) begin
                        state_q     <= StResp;
                        result_q    <= rd_word;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= rd_word;
                        rsp_err_o   <= 1'b0;
                    end else begin
                        state_q    <= StWrHi;
                        result_q   <= arith;
                        regEn_o    <= 1'b1;
                        regRW_o    <= 1'b1;
                        regSel_o   <= hi_sel;
                        regWdata_o <= arith[15:8];
                    end
                end
                StWrHi: begin
                    state_q    <= StWrLo;
                    regEn_o    <= 1'b1;
                    regRW_o    <= 1'b1;
                    regSel_o   <= lo_sel;
                    regWdata_o <= result_q[7:0];
                end
                StWrLo: begin
                    state_q     <= StResp;
                    rsp_valid_o <= 1'b1;
                    rsp_data_o  <= result_q;
                    rsp_err_o   <= 1'b0;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    rsp_valid_o <= 1'b0;
                    cmd_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_pair_sequencer.md
# reg_pair_sequencer

Sequencer that performs 16-bit register-pair operations (read, write, increment, decrement) on BC, DE and HL through the CPU register file's single 8-bit access port. It sits between the CPU control unit and the register file, splits each 16-bit command into ordered byte accesses, and returns the 16-bit result over a valid/ready response channel. One command is in flight at a time.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op_i  in  2  00 READ, 01 WRITE, 10 INC, 11 DEC
- cmd_pair_i  in  2  00 BC, 01 DE, 10 HL, 11 illegal
- cmd_wdata_i  in  16  WRITE data, high byte to first register of the pair
- rsp_valid_o  out  1  response available, held until accepted
- rsp_ready_i  in  1  consumer accepts response
- rsp_data_o  out  16  READ: pair value; WRITE: written value; INC/DEC: new value
- rsp_err_o  out  1  illegal pair code; rsp_data_o = 0
- regEn_o  out  1  register file access strobe
- regRW_o  out  1  1 = write, 0 = read
- regSel_o  out  3  B=000, C=001, D=010, E=011, H=100, L=101
- regWdata_o  out  8  write byte
- regRdata_i  in  8  read byte, valid in the cycle after a read strobe

## Operation
- Handshake: command accepted when cmd_valid_i & cmd_ready_o; response retires when rsp_valid_o & rsp_ready_i. Command inputs are captured at accept and are ignored afterwards.
- Pair mapping: hi/lo = B/C, D/E, H/L. The high byte is always accessed first.
- States: IDLE, RD_HI, RD_LO, RD_WAIT, WR_HI, WR_LO, RESP.
- IDLE -> RESP (err=1) on accept with pair 11. No register file access is made.
- READ: IDLE -> RD_HI -> RD_LO -> RD_WAIT -> RESP.
- WRITE: IDLE -> WR_HI -> WR_LO -> RESP.
- INC/DEC: IDLE -> RD_HI -> RD_LO -> RD_WAIT -> WR_HI -> WR_LO -> RESP.
- RD_HI: regEn_o=1, regRW_o=0, regSel_o=hi.
- RD_LO: read of lo. The hi byte is captured from regRdata_i.
- RD_WAIT: no strobe. The lo byte is captured. For INC/DEC, the result register loads {hi,lo} ± 1 in this cycle.
- WR_HI / WR_LO: regEn_o=1, regRW_o=1, regWdata_o = result[15:8] / result[7:0].
- RESP: rsp_valid_o=1, then -> IDLE on rsp_ready_i.
- Arithmetic: 16-bit modulo. 0xFFFF+1 = 0x0000 and 0x0000−1 = 0xFFFF. The carry between bytes propagates (0x12FF+1 = 0x1300). No flags are produced.
- Outside the access states: regEn_o=0, regRW_o=0, regSel_o=000, regWdata_o=0.
- Reset values: cmd_ready_o=1 (IDLE), rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, all reg* outputs 0.

## Timing
- Cycle 0 is the accept edge. Latency to rsp_valid_o is READ 4 cycles, WRITE 3, INC/DEC 6, illegal pair 1.
- Back-to-back: a new command can be accepted the cycle after the response retires. With rsp_ready_i held high, a WRITE occupies 4 cycles including IDLE.
- rsp_valid_o, rsp_data_o and rsp_err_o stay stable while rsp_ready_i is low. The register file is not touched while stalled.
- Reset mid-operation: the FSM goes to IDLE immediately and all outputs return to their reset values. A write interrupted after WR_HI leaves hi updated and lo unchanged. This is accepted behaviour and is not repaired.
- cmd_valid_i asserted outside IDLE has no effect.

## Test plan
- Reset, then WRITE DE=0xBEEF -> WR_HI cycle 1: sel=010, wdata=0xBE; WR_LO cycle 2: sel=011, wdata=0xEF; rsp_valid cycle 3 with data=0xBEEF, err=0.
- READ HL, with the model returning H=0x12 and L=0x34 one cycle after each read strobe -> read strobes in cycles 1–2, rsp_valid in cycle 4 with data=0x1234.
- INC BC from 0x12FF -> writes B=0x13 then C=0x00, rsp_data=0x1300 in cycle 6. INC from 0xFFFF -> 0x0000. DEC from 0x0000 -> 0xFFFF.
- Pair 11 with any op -> rsp_valid in cycle 1 with err=1 and data=0x0000, regEn_o never asserted.
- rsp_ready_i held low for 5 cycles -> response is stable, cmd_ready_o=0, a second cmd_valid_i is ignored. Release ready -> cmd_ready_o goes high the next cycle.
- rst_ni asserted in the cycle after WR_HI of a WRITE HL=0xAAAA (prior value 0x5555) -> outputs clear asynchronously, H=0xAA and L=0x55 remain, and the next command behaves normally.
